// File: rtl/sdsu_pkg.sv
// rtl/sdsu_pkg.sv - shared state encoding, defaults and sizing helpers for the SDSU master
package sdsu_pkg;

  localparam int OP_W_DEFAULT  = 16;
  localparam int RES_W_DEFAULT = 32;
  localparam int TIMEOUT_MIN   = 20;
  localparam int SETTLE_MIN    = 1;

  typedef enum logic [2:0] {
    ST_SETTLE,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_LOW,
    ST_WAIT_HIGH,
    ST_RESP,
    ST_ERR
  } sdsu_state_e;

  // Counter width able to hold the larger of the two terminal values.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sdsu_master_if.sv
// rtl/sdsu_master_if.sv - user request/response port and slave bus of sdsu_master
interface sdsu_master_if
  import sdsu_pkg::*;
#(
  parameter int OP_W  = OP_W_DEFAULT,
  parameter int RES_W = RES_W_DEFAULT
);
  logic             req_valid;
  logic             req_ready;
  logic [OP_W-1:0]  req_a;
  logic [OP_W-1:0]  req_b;
  logic             resp_valid;
  logic [RES_W-1:0] resp_data;
  logic             resp_err;
  logic             busy;
  logic             valid_signal;
  logic             start_calc;
  logic [OP_W-1:0]  A_in;
  logic [OP_W-1:0]  B_in;
  logic [RES_W-1:0] read_data;
  logic             ready_signal;

  modport master (
    input  req_valid, req_a, req_b, read_data, ready_signal,
    output req_ready, resp_valid, resp_data, resp_err, busy,
           valid_signal, start_calc, A_in, B_in
  );

  modport slave (
    output req_valid, req_a, req_b, read_data, ready_signal,
    input  req_ready, resp_valid, resp_data, resp_err, busy,
           valid_signal, start_calc, A_in, B_in
  );
endinterface

// File: rtl/sdsu_timer.sv
// rtl/sdsu_timer.sv - saturating up-counter, cleared while idle, flags when limit is reached
module sdsu_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  input  logic [W-1:0] limit,
  output logic         done
);
  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign done = (cnt_q >= limit);

  always_comb begin
    cnt_d = '0;
    if (run) begin
      cnt_d = done ? cnt_q : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/sdsu_master.sv
// rtl/sdsu_master.sv - SDSU multiply-slave initiator; product recovered as accumulator delta
module sdsu_master
  import sdsu_pkg::*;
#(
  parameter int OP_W       = OP_W_DEFAULT,
  parameter int RES_W      = RES_W_DEFAULT,
  parameter int TIMEOUT    = 64,
  parameter int SETTLE     = 24,
  parameter bit DELTA_MODE = 1'b1
) (
  input logic           clk,
  input logic           rst,
  sdsu_master_if.master bus
);
  localparam int TIMEOUT_EFF = (TIMEOUT < TIMEOUT_MIN) ? TIMEOUT_MIN : TIMEOUT;
  localparam int SETTLE_EFF  = (SETTLE < SETTLE_MIN) ? SETTLE_MIN : SETTLE;
  localparam int CNT_W       = cnt_width(TIMEOUT_EFF, SETTLE_EFF);

  sdsu_state_e      state_q, state_d;
  logic [OP_W-1:0]  a_q, a_d;
  logic [OP_W-1:0]  b_q, b_d;
  logic [RES_W-1:0] base_q, base_d;
  logic [RES_W-1:0] data_q, data_d;
  logic             req_ready_q, req_ready_d;
  logic             busy_q, busy_d;
  logic             issue_q, issue_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_err_q, resp_err_d;

  logic             tmr_run;
  logic             tmr_done;
  logic [CNT_W-1:0] tmr_limit;

  // One counter serves both the post-reset settle window and the op timeout.
  assign tmr_run   = (state_q == ST_SETTLE) || (state_q == ST_WAIT_LOW) ||
                     (state_q == ST_WAIT_HIGH);
  assign tmr_limit = (state_q == ST_SETTLE) ? CNT_W'(SETTLE_EFF - 1)
                                            : CNT_W'(TIMEOUT_EFF - 1);

  sdsu_timer #(.W(CNT_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .run   (tmr_run),
    .limit (tmr_limit),
    .done  (tmr_done)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    base_d  = base_q;
    data_d  = data_q;
    case (state_q)
      ST_SETTLE: begin
        if (tmr_done) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (bus.req_valid) begin
          state_d = ST_ISSUE;
          a_d     = bus.req_a;
          b_d     = bus.req_b;
          base_d  = bus.read_data;
        end
      end
      ST_ISSUE: state_d = ST_WAIT_LOW;
      ST_WAIT_LOW: begin
        // Only a clean low counts; a stale high or unknown keeps waiting.
        if (bus.ready_signal == 1'b0) state_d = ST_WAIT_HIGH;
        else if (tmr_done)            state_d = ST_ERR;
      end
      ST_WAIT_HIGH: begin
        if (bus.ready_signal == 1'b1) begin
          state_d = ST_RESP;
          data_d  = DELTA_MODE ? (bus.read_data - base_q) : bus.read_data;
        end else if (tmr_done) begin
          state_d = ST_ERR;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_SETTLE;
      default: state_d = ST_SETTLE;
    endcase

    req_ready_d  = (state_d == ST_IDLE);
    busy_d       = (state_d != ST_IDLE);
    issue_d      = (state_d == ST_ISSUE);
    resp_valid_d = (state_d == ST_RESP);
    resp_err_d   = (state_d == ST_ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_SETTLE;
      a_q          <= '0;
      b_q          <= '0;
      base_q       <= '0;
      data_q       <= '0;
      req_ready_q  <= 1'b0;
      busy_q       <= 1'b1;
      issue_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      base_q       <= base_d;
      data_q       <= data_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
      issue_q      <= issue_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.busy         = busy_q;
  assign bus.valid_signal = issue_q;
  assign bus.start_calc   = issue_q;
  assign bus.A_in         = a_q;
  assign bus.B_in         = b_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_err     = resp_err_q;
  assign bus.resp_data    = data_q;
endmodule

// File: tb/tb_sdsu_master.sv
// tb/tb_sdsu_master.sv - directed bench for sdsu_master with behavioural multiply slaves
module tb_sdsu_master;
  localparam int OP_W    = 16;
  localparam int RES_W   = 32;
  localparam int TIMEOUT = 64;
  localparam int SETTLE  = 24;
  localparam int SLV_LAT = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sdsu_master_if #(.OP_W(OP_W), .RES_W(RES_W)) bus_d ();
  sdsu_master_if #(.OP_W(OP_W), .RES_W(RES_W)) bus_r ();

  sdsu_master #(.OP_W(OP_W), .RES_W(RES_W), .TIMEOUT(TIMEOUT), .SETTLE(SETTLE),
                .DELTA_MODE(1'b1)) u_dut_d (.clk(clk), .rst(rst), .bus(bus_d));
  sdsu_master #(.OP_W(OP_W), .RES_W(RES_W), .TIMEOUT(TIMEOUT), .SETTLE(SETTLE),
                .DELTA_MODE(1'b0)) u_dut_r (.clk(clk), .rst(rst), .bus(bus_r));

  // Slave: never reset, accumulates A*B, ready drops on valid and rises SLV_LAT cycles later.
  logic [31:0] acc_d = 32'h1234_5678;
  logic [31:0] acc_r = 32'h0;
  logic        rdy_d = 1'b1;
  logic        rdy_r = 1'b1;
  logic        stub  = 1'b0;
  logic [3:0]  cd_d  = 4'd0;
  logic [3:0]  cd_r  = 4'd0;
  logic [15:0] sa_d, sb_d, sa_r, sb_r;

  always @(posedge clk) begin
    if (bus_d.valid_signal) begin
      rdy_d <= 1'b0; cd_d <= 4'(SLV_LAT); sa_d <= bus_d.A_in; sb_d <= bus_d.B_in;
    end else if (cd_d != 0) begin
      cd_d <= cd_d - 4'd1;
      if (cd_d == 4'd1) begin acc_d <= acc_d + sa_d * sb_d; rdy_d <= 1'b1; end
    end
    if (bus_r.valid_signal) begin
      rdy_r <= 1'b0; cd_r <= 4'(SLV_LAT); sa_r <= bus_r.A_in; sb_r <= bus_r.B_in;
    end else if (cd_r != 0) begin
      cd_r <= cd_r - 4'd1;
      if (cd_r == 4'd1) begin acc_r <= acc_r + sa_r * sb_r; rdy_r <= 1'b1; end
    end
  end

  assign bus_d.read_data    = acc_d;
  assign bus_d.ready_signal = rdy_d & ~stub;
  assign bus_r.read_data    = acc_r;
  assign bus_r.ready_signal = rdy_r;

  int issue_cnt = 0;
  always @(negedge clk) if (bus_d.valid_signal) issue_cnt++;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  function automatic logic rv(input bit r);
    return r ? bus_r.resp_valid : bus_d.resp_valid;
  endfunction
  function automatic logic re(input bit r);
    return r ? bus_r.resp_err : bus_d.resp_err;
  endfunction
  function automatic logic rr(input bit r);
    return r ? bus_r.req_ready : bus_d.req_ready;
  endfunction
  function automatic logic [31:0] rd(input bit r);
    return r ? bus_r.resp_data : bus_d.resp_data;
  endfunction

  task automatic drive_req(input bit r, input logic v, input logic [15:0] a, input logic [15:0] b);
    if (r) begin bus_r.req_valid = v; bus_r.req_a = a; bus_r.req_b = b; end
    else   begin bus_d.req_valid = v; bus_d.req_a = a; bus_d.req_b = b; end
  endtask

  task automatic wait_ready(input bit r, input string nm);
    int k;
    k = 0;
    while (!rr(r) && k < 100) begin @(negedge clk); k++; end
    chk({nm, "_ready_wait"}, 32'(rr(r)), 32'd1);
  endtask

  task automatic run_op(input bit r, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp, input string nm);
    int k;
    wait_ready(r, nm);
    drive_req(r, 1'b1, a, b);
    @(negedge clk);
    drive_req(r, 1'b0, a, b);
    k = 0;
    while (!rv(r) && !re(r) && k < 50) begin @(negedge clk); k++; end
    chk({nm, "_valid"}, 32'(rv(r)), 32'd1);
    chk({nm, "_data"}, rd(r), exp);
    chk({nm, "_err"}, 32'(re(r)), 32'd0);
    @(negedge clk);
    chk({nm, "_pulse"}, 32'(rv(r)), 32'd0);
    chk({nm, "_next_ready"}, 32'(rr(r)), 32'd1);
  endtask

  typedef struct {
    bit          raw;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int k;
    int hi_cnt;
    int i0;
    bit saw_valid;

    vecs[0] = '{1'b0, 16'd3,      16'd5,      32'd15};
    vecs[1] = '{1'b0, 16'hFFFF,   16'hFFFF,   32'hFFFE_0001};
    vecs[2] = '{1'b0, 16'd0,      16'h1234,   32'd0};
    vecs[3] = '{1'b0, 16'h8000,   16'd2,      32'h0001_0000};
    vecs[4] = '{1'b0, 16'hFFFF,   16'd1,      32'h0000_FFFF};
    vecs[5] = '{1'b0, 16'h1234,   16'h0100,   32'h0012_3400};
    vecs[6] = '{1'b1, 16'd2,      16'd2,      32'd4};
    vecs[7] = '{1'b1, 16'd2,      16'd2,      32'd8};

    rst = 1'b1;
    drive_req(1'b0, 1'b0, 16'd0, 16'd0);
    drive_req(1'b1, 1'b0, 16'd0, 16'd0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_ready",    32'(bus_d.req_ready),    32'd0);
    chk("rst_resp_valid",   32'(bus_d.resp_valid),   32'd0);
    chk("rst_resp_err",     32'(bus_d.resp_err),     32'd0);
    chk("rst_busy",         32'(bus_d.busy),         32'd1);
    chk("rst_valid_signal", 32'(bus_d.valid_signal), 32'd0);
    chk("rst_start_calc",   32'(bus_d.start_calc),   32'd0);
    chk("rst_a_in",         32'(bus_d.A_in),         32'd0);
    chk("rst_b_in",         32'(bus_d.B_in),         32'd0);
    chk("rst_resp_data",    bus_d.resp_data,         32'd0);

    rst = 1'b0;
    k = 0;
    while (!bus_d.req_ready && k < 100) begin @(negedge clk); k++; end
    chk("settle_cycles", 32'(k), 32'(SETTLE));

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].raw, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // req_valid held through the whole op: one issue, req_ready stays low.
    wait_ready(1'b0, "held");
    i0 = issue_cnt;
    drive_req(1'b0, 1'b1, 16'd6, 16'd7);
    @(negedge clk);
    hi_cnt = 0;
    k = 0;
    while (!bus_d.resp_valid && k < 50) begin
      if (bus_d.req_ready) hi_cnt++;
      @(negedge clk);
      k++;
    end
    drive_req(1'b0, 1'b0, 16'd6, 16'd7);
    chk("held_resp_valid", 32'(bus_d.resp_valid), 32'd1);
    chk("held_resp_data",  bus_d.resp_data,       32'd42);
    chk("held_ready_low",  32'(hi_cnt),           32'd0);
    chk("held_issue_once", 32'(issue_cnt - i0),   32'd1);
    @(negedge clk);
    chk("held_idle_after", 32'(bus_d.req_ready),  32'd1);

    // Slave ready stuck low: timeout error, then a full settle window.
    stub = 1'b1;
    wait_ready(1'b0, "tmo");
    drive_req(1'b0, 1'b1, 16'd3, 16'd3);
    @(negedge clk);
    drive_req(1'b0, 1'b0, 16'd3, 16'd3);
    k = 1;
    saw_valid = 1'b0;
    while (!bus_d.resp_err && k < 200) begin
      if (bus_d.resp_valid) saw_valid = 1'b1;
      @(negedge clk);
      k++;
    end
    chk("tmo_err",        32'(bus_d.resp_err), 32'd1);
    chk("tmo_cycles",     32'(k),              32'(TIMEOUT + 2));
    chk("tmo_no_valid",   32'(saw_valid),      32'd0);
    k = 0;
    while (!bus_d.req_ready && k < 100) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        chk("tmo_err_pulse", 32'(bus_d.resp_err), 32'd0);
        chk("tmo_busy",      32'(bus_d.busy),     32'd1);
      end
    end
    chk("tmo_settle", 32'(k), 32'(SETTLE + 1));
    stub = 1'b0;

    // Reset while waiting for the slave to finish.
    wait_ready(1'b0, "mid");
    drive_req(1'b0, 1'b1, 16'd5, 16'd5);
    @(negedge clk);
    drive_req(1'b0, 1'b0, 16'd5, 16'd5);
    @(negedge clk);
    @(negedge clk);
    chk("mid_pre_busy", 32'(bus_d.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_valid_signal", 32'(bus_d.valid_signal), 32'd0);
    chk("mid_req_ready",    32'(bus_d.req_ready),    32'd0);
    chk("mid_resp_valid",   32'(bus_d.resp_valid),   32'd0);
    chk("mid_busy",         32'(bus_d.busy),         32'd1);
    chk("mid_a_in",         32'(bus_d.A_in),         32'd0);
    chk("mid_resp_data",    bus_d.resp_data,         32'd0);
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    saw_valid = 1'b0;
    while (!bus_d.req_ready && k < 100) begin
      if (bus_d.resp_valid) saw_valid = 1'b1;
      @(negedge clk);
      k++;
    end
    chk("mid_settle",   32'(k),         32'(SETTLE));
    chk("mid_no_valid", 32'(saw_valid), 32'd0);
    run_op(1'b0, 16'd7, 16'd9, 32'd63, "post_rst");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
